// File: rtl/bus_sink_regs_pkg.sv
// Shared constants for the datapath bus sink: default widths, rin bit
// positions and ALU operation codes.
package bus_sink_regs_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_PC_W   = 6;

  // Bit positions within the rin load-enable vector
  localparam int R0 = 0;
  localparam int R1 = 1;
  localparam int R2 = 2;
  localparam int R3 = 3;
  localparam int R4 = 4;
  localparam int R5 = 5;
  localparam int R6 = 6;
  localparam int R7 = 7;

  // ALU operation select carried on addsub
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bus_sink_regs_regn.sv
// Load-enable register with asynchronous active-low clear. Used for every
// plain bus-loaded register in the sink (r0..r6, A, G, ADDR, DOUT).
module bus_sink_regs_regn #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q
);

  logic [W-1:0] val_d;
  logic [W-1:0] val_q;

  // Next value: take the input when enabled, otherwise hold
  always_comb begin
    val_d = val_q;
    if (en) begin
      val_d = d_in;
    end
  end

  // State register, cleared immediately by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/bus_sink_regs.sv
// Destination side of the shared datapath bus: general registers r0..r6,
// program counter r7, accumulator A, ALU result G, memory address ADDR,
// memory write data DOUT and write flag W. All loads take one edge.
module bus_sink_regs
  import bus_sink_regs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] bus,
  input  logic [7:0]        rin,
  input  logic              incr_pc,
  input  logic              ain,
  input  logic              gin,
  input  logic              addsub,
  input  logic              addr_in,
  input  logic              dout_in,
  input  logic              w_d,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [PC_W-1:0]   r7,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] g,
  output logic [PC_W-1:0]   addr,
  output logic [DATA_W-1:0] dout,
  output logic              w
);

  logic [DATA_W-1:0] gp [0:6];
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   r7_d;
  logic [PC_W-1:0]   r7_q;
  logic              wflag_d;
  logic              wflag_q;

  // General registers; several rin bits set at once simply broadcast the bus
  for (genvar i = 0; i < 7; i++) begin : g_gp
    bus_sink_regs_regn #(.W(DATA_W)) u_gp (
      .clock  (clock),
      .resetn (resetn),
      .en     (rin[i]),
      .d_in   (bus),
      .q      (gp[i])
    );
  end

  assign r0 = gp[R0];
  assign r1 = gp[R1];
  assign r2 = gp[R2];
  assign r3 = gp[R3];
  assign r4 = gp[R4];
  assign r5 = gp[R5];
  assign r6 = gp[R6];

  // Accumulator
  bus_sink_regs_regn #(.W(DATA_W)) u_a (
    .clock  (clock),
    .resetn (resetn),
    .en     (ain),
    .d_in   (bus),
    .q      (a)
  );

  // ALU uses the currently registered A, so a simultaneous ain sees old A
  always_comb begin
    alu_res = a + bus;
    if (addsub == OP_SUB) begin
      alu_res = a - bus;
    end
  end

  // ALU result register
  bus_sink_regs_regn #(.W(DATA_W)) u_g (
    .clock  (clock),
    .resetn (resetn),
    .en     (gin),
    .d_in   (alu_res),
    .q      (g)
  );

  // Memory address register takes only the low PC_W bits of the bus
  bus_sink_regs_regn #(.W(PC_W)) u_addr (
    .clock  (clock),
    .resetn (resetn),
    .en     (addr_in),
    .d_in   (bus[PC_W-1:0]),
    .q      (addr)
  );

  // Memory write data register
  bus_sink_regs_regn #(.W(DATA_W)) u_dout (
    .clock  (clock),
    .resetn (resetn),
    .en     (dout_in),
    .d_in   (bus),
    .q      (dout)
  );

  // Program counter next value: a bus load overrides increment; wraps mod 2^PC_W
  always_comb begin
    r7_d = r7_q;
    if (rin[R7]) begin
      r7_d = bus[PC_W-1:0];
    end else if (incr_pc) begin
      r7_d = r7_q + PC_W'(1);
    end
  end

  // Write flag next value: updated together with DOUT, otherwise sticky
  always_comb begin
    wflag_d = wflag_q;
    if (dout_in) begin
      wflag_d = w_d;
    end
  end

  // Program counter and write flag state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r7_q    <= '0;
      wflag_q <= 1'b0;
    end else begin
      r7_q    <= r7_d;
      wflag_q <= wflag_d;
    end
  end

  assign r7 = r7_q;
  assign w  = wflag_q;

endmodule

// File: tb/tb_bus_sink_regs.sv
// Directed bench for bus_sink_regs: expected register values are queued as
// stimulus is applied and compared once the DUT has taken the clock edge.
module tb_bus_sink_regs;

  logic        clock;
  logic        resetn;
  logic [15:0] bus;
  logic [7:0]  rin;
  logic        incr_pc, ain, gin, addsub, addr_in, dout_in, w_d;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, a, g, dout;
  logic [5:0]  r7, addr;
  logic        w;

  bus_sink_regs dut (
    .clock(clock), .resetn(resetn), .bus(bus), .rin(rin), .incr_pc(incr_pc),
    .ain(ain), .gin(gin), .addsub(addsub), .addr_in(addr_in),
    .dout_in(dout_in), .w_d(w_d),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .a(a), .g(g), .addr(addr), .dout(dout), .w(w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {F_R0, F_R1, F_R2, F_R3, F_R4, F_R5, F_R6, F_R7,
                    F_A, F_G, F_ADDR, F_DOUT, F_W} field_t;

  typedef struct {
    field_t      fld;
    logic [15:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   fail_cnt  = 0;

  function automatic logic [15:0] observe(field_t f);
    case (f)
      F_R0:   return r0;
      F_R1:   return r1;
      F_R2:   return r2;
      F_R3:   return r3;
      F_R4:   return r4;
      F_R5:   return r5;
      F_R6:   return r6;
      F_R7:   return {10'd0, r7};
      F_A:    return a;
      F_G:    return g;
      F_ADDR: return {10'd0, addr};
      F_DOUT: return dout;
      default: return {15'd0, w};
    endcase
  endfunction

  task automatic expect_val(input field_t f, input logic [15:0] v, input string tag);
    exp_t e;
    e.fld = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int i = 0; i <= int'(F_W); i++) begin
      expect_val(field_t'(i), 16'h0000, tag);
    end
  endtask

  // Pop every queued expectation and compare against the DUT outputs
  task automatic drain();
    exp_t e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.fld);
      tests_run++;
      assert (obs === e.val) else begin
        fail_cnt++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle_inputs();
    rin = 8'h00; incr_pc = 0; ain = 0; gin = 0; addsub = 0;
    addr_in = 0; dout_in = 0; w_d = 0;
  endtask

  // Advance past the next rising edge, then compare
  task automatic step();
    @(posedge clock);
    #1;
    drain();
    idle_inputs();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus = 16'h0000;
    idle_inputs();
    resetn = 1'b0;
    #12;
    expect_all_zero("reset_init");
    drain();
    resetn = 1'b1;
    @(posedge clock); #1;

    // Fill r3, dout and w so the asynchronous reset has something to clear
    bus = 16'h1234; rin = 8'b0000_1000; dout_in = 1; w_d = 1;
    expect_val(F_R3, 16'h1234, "load_r3");
    expect_val(F_DOUT, 16'h1234, "load_dout");
    expect_val(F_W, 16'h0001, "load_w");
    step();

    // Reset between edges with loads pending: outputs clear before any edge
    bus = 16'h5555; rin = 8'hFF; ain = 1; gin = 1; addr_in = 1; dout_in = 1; w_d = 1;
    #2 resetn = 1'b0;
    #1;
    expect_all_zero("async_reset");
    drain();
    idle_inputs();
    #1 resetn = 1'b1;
    expect_all_zero("post_reset_hold");
    step();

    // Single-register load
    bus = 16'hBEEF; rin = 8'b0000_0100;
    expect_val(F_R2, 16'hBEEF, "r2_load");
    expect_val(F_R1, 16'h0000, "r1_untouched");
    expect_val(F_R3, 16'h0000, "r3_untouched");
    expect_val(F_R7, 16'h0000, "r7_untouched");
    expect_val(F_A,  16'h0000, "a_untouched");
    step();

    // PC load, wrap, and load-over-increment priority
    bus = 16'h003F; rin = 8'b1000_0000;
    expect_val(F_R7, 16'd63, "r7_load63");
    step();
    incr_pc = 1;
    expect_val(F_R7, 16'd0, "r7_wrap");
    step();
    bus = 16'hFF05; rin = 8'b1000_0000; incr_pc = 1;
    expect_val(F_R7, 16'd5, "r7_load_wins");
    step();
    incr_pc = 1;
    expect_val(F_R7, 16'd6, "r7_incr");
    step();
    expect_val(F_R7, 16'd6, "r7_hold");
    expect_val(F_R2, 16'hBEEF, "r2_hold");
    step();

    // ALU subtract and add
    bus = 16'h0003; ain = 1;
    expect_val(F_A, 16'h0003, "a_load");
    step();
    bus = 16'h0005; gin = 1; addsub = 1;
    expect_val(F_G, 16'hFFFE, "alu_sub");
    step();
    bus = 16'h0005; gin = 1; addsub = 0;
    expect_val(F_G, 16'h0008, "alu_add");
    step();

    // ain and gin together: G sees old A
    bus = 16'h0010; ain = 1;
    expect_val(F_A, 16'h0010, "a_load10");
    step();
    bus = 16'h0001; ain = 1; gin = 1; addsub = 0;
    expect_val(F_G, 16'h0011, "alu_old_a");
    expect_val(F_A, 16'h0001, "a_new");
    step();

    // Memory interface registers
    bus = 16'h002A; addr_in = 1;
    expect_val(F_ADDR, 16'h002A, "addr_load");
    step();
    bus = 16'h00FF; dout_in = 1; w_d = 1;
    expect_val(F_DOUT, 16'h00FF, "dout_load");
    expect_val(F_W, 16'h0001, "w_set");
    step();
    bus = 16'h1111;
    expect_val(F_W, 16'h0001, "w_sticky");
    expect_val(F_DOUT, 16'h00FF, "dout_hold");
    step();
    bus = 16'h00C1; addr_in = 1;
    expect_val(F_ADDR, 16'h0001, "addr_low_bits");
    step();
    bus = 16'h0042; dout_in = 1; w_d = 0;
    expect_val(F_W, 16'h0000, "w_clear");
    expect_val(F_DOUT, 16'h0042, "dout_reload");
    step();

    // Broadcast to several general registers
    bus = 16'h7777; rin = 8'b0101_0011;
    expect_val(F_R0, 16'h7777, "bcast_r0");
    expect_val(F_R1, 16'h7777, "bcast_r1");
    expect_val(F_R4, 16'h7777, "bcast_r4");
    expect_val(F_R6, 16'h7777, "bcast_r6");
    expect_val(F_R2, 16'hBEEF, "bcast_r2_hold");
    expect_val(F_R5, 16'h0000, "bcast_r5_hold");
    expect_val(F_R7, 16'd6, "bcast_r7_hold");
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
